mem_arbiter: RTL and testbench

//  Shares the single fixed-latency main-memory port between the I-cache refill path
//  (fetchStage) and the D-cache refill/writeback path (memoryStage).
//  - Sequences one line transfer at a time, using an internal latency counter.
//  - Returns data and a one-cycle ack to the owning requester.
//  - Round-robin between the two requesters; D-cache wins the first tie after reset.
//  - While a requester's transaction is outstanding, its cache holds CacheStall.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/arb_rr2.sv | 14 +
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the main-memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int DEF_LINE_SIZE   = 128;
  localparam int DEF_MEM_LATENCY = 5;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin picker, bit0 = I-cache, bit1 = D-cache
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant
);

  // On a tie the requester that did not own the last transfer wins.
  assign grant[0] = req[0] & (~req[1] | (last_owner == OWNER_D));
  assign grant[1] = req[1] & (~req[0] | (last_owner == OWNER_I));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency memory port between I-cache and D-cache refills
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = DEF_LINE_SIZE,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_ack,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_last_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_ic_rdata;
  logic [LINE_W-1:0] r_dc_rdata;
  logic              r_ic_ack;
  logic              r_dc_ack;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;

  logic [1:0]        w_grant;
  logic [ADDR_W-1:0] w_req_addr;

  arb_rr2 u_rr (
    .req        ({dc_req, ic_req}),
    .last_owner (r_last_owner),
    .grant      (w_grant)
  );

  assign w_req_addr = w_grant[1] ? dc_addr : ic_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWNER_I;
      r_last_owner <= OWNER_I;
      r_cnt        <= '0;
      r_ic_rdata   <= '0;
      r_dc_rdata   <= '0;
      r_ic_ack     <= 1'b0;
      r_dc_ack     <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_ic_ack <= 1'b0;
      r_dc_ack <= 1'b0;
      r_mem_en <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (|w_grant) begin
            r_owner      <= w_grant[1];
            r_last_owner <= w_grant[1];
            r_mem_we     <= w_grant[1] & dc_we;
            r_mem_addr   <= w_req_addr & ALIGN_MASK;
            r_mem_wdata  <= (w_grant[1] & dc_we) ? dc_wdata : '0;
            r_mem_en     <= 1'b1;
            r_cnt        <= CNT_W'(MEM_LATENCY);
            r_state      <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          // The counter starts counting on the cycle after the command strobe,
          // so it reaches 1 exactly when mem_rdata becomes valid.
          if (!r_mem_en) begin
            if (r_cnt == CNT_W'(1)) begin
              if (!r_mem_we) begin
                if (r_owner == OWNER_D) r_dc_rdata <= mem_rdata;
                else                    r_ic_rdata <= mem_rdata;
              end
              r_ic_ack <= (r_owner == OWNER_I);
              r_dc_ack <= (r_owner == OWNER_D);
              r_state  <= ARB_RESP;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        ARB_RESP: begin
          r_mem_we <= 1'b0;
          r_state  <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign ic_rdata  = r_ic_rdata;
  assign dc_rdata  = r_dc_rdata;
  assign ic_ack    = r_ic_ack;
  assign dc_ack    = r_dc_ack;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (latency 5 and latency 1 builds)
module tb_mem_arbiter;

  localparam int L0 = 5;
  localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         ic_req, ic_ack, dc_req, dc_we, dc_ack, mem_en, mem_we, busy;
  logic [31:0]  ic_addr, dc_addr, mem_addr;
  logic [127:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;

  logic         ic_req1, ic_ack1, dc_req1, dc_we1, dc_ack1, mem_en1, mem_we1, busy1;
  logic [31:0]  ic_addr1, dc_addr1, mem_addr1;
  logic [127:0] ic_rdata1, dc_rdata1, dc_wdata1, mem_wdata1, mem_rdata1;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .MEM_LATENCY(L0)) u_dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ack(dc_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_rdata(ic_rdata1), .ic_ack(ic_ack1),
    .dc_req(dc_req1), .dc_we(dc_we1), .dc_addr(dc_addr1), .dc_wdata(dc_wdata1),
    .dc_rdata(dc_rdata1), .dc_ack(dc_ack1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'h1111_0000, ~a, a + 32'h5, 32'hC0DE_0000 | a};
  endfunction

  // Memory models: read data is valid only in the cycle exactly L after mem_en.
  logic         p0_v [1:L0];
  logic [127:0] p0_d [1:L0];
  logic         p1_v;
  logic [127:0] p1_d;

  always @(posedge clk) begin
    p0_v[1] <= mem_en & ~mem_we;
    p0_d[1] <= line_of(mem_addr);
    for (int i = 2; i <= L0; i++) begin
      p0_v[i] <= p0_v[i-1];
      p0_d[i] <= p0_d[i-1];
    end
    p1_v <= mem_en1 & ~mem_we1;
    p1_d <= line_of(mem_addr1);
  end

  assign mem_rdata  = p0_v[L0] ? p0_d[L0] : JUNK;
  assign mem_rdata1 = p1_v ? p1_d : JUNK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0]  en_addr;
  logic         en_we;
  logic [127:0] en_wdata;
  int           ack_who[$];
  int           ack_cyc[$];

  task automatic txn(input logic is_d, input logic we, input logic [31:0] addr,
                     input logic [127:0] wd, output int t_en, output int t_ack,
                     output logic saw_other);
    int t0;
    t_en = -1; t_ack = -1; saw_other = 1'b0;
    if (is_d) begin dc_req = 1'b1; dc_we = we; dc_addr = addr; dc_wdata = wd; end
    else begin ic_req = 1'b1; ic_addr = addr; end
    t0 = cyc;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_en && t_en < 0) begin
        t_en = cyc - t0; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
      end
      if (is_d ? ic_ack : dc_ack) saw_other = 1'b1;
      if (is_d ? dc_ack : ic_ack) begin
        t_ack = cyc - t0;
        if (is_d) dc_req = 1'b0; else ic_req = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic collect(input int n, input logic hold_d);
    ack_who.delete(); ack_cyc.delete();
    for (int k = 0; k < 200 && ack_who.size() < n; k++) begin
      @(negedge clk);
      if (ic_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); ic_req = 1'b0; end
      if (dc_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); if (!hold_d) dc_req = 1'b0; end
    end
    dc_req = 1'b0;
    while (ack_who.size() < n) begin ack_who.push_back(-1); ack_cyc.push_back(0); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   te, ta, nack, t0;
    logic oth;
    rst = 1'b0;
    ic_req = 0; ic_addr = 0; dc_req = 0; dc_we = 0; dc_addr = 0; dc_wdata = 0;
    ic_req1 = 0; ic_addr1 = 0; dc_req1 = 0; dc_we1 = 0; dc_addr1 = 0; dc_wdata1 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_acks", {ic_ack, dc_ack}, 0);
    check("rst_ic_rdata", ic_rdata, 0);
    check("rst_dc_rdata", dc_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // I-cache read
    txn(1'b0, 1'b0, 32'h104, '0, te, ta, oth);
    check("t1_en_lat", te, 1);
    check("t1_addr", en_addr, 32'h100);
    check("t1_we", en_we, 0);
    check("t1_ack_lat", ta, L0 + 2);
    check("t1_ic_rdata", ic_rdata, line_of(32'h100));
    check("t1_no_dc_ack", oth, 0);

    // D-cache writeback
    txn(1'b1, 1'b1, 32'h200, {16{8'hA5}}, te, ta, oth);
    check("t2_en_lat", te, 1);
    check("t2_we", en_we, 1);
    check("t2_addr", en_addr, 32'h200);
    check("t2_wdata", en_wdata, {16{8'hA5}});
    check("t2_ack_lat", ta, L0 + 2);
    check("t2_dc_rdata_kept", dc_rdata, 0);
    check("t2_ic_rdata_kept", ic_rdata, line_of(32'h100));
    check("t2_no_ic_ack", oth, 0);

    // D-cache refill, unaligned address
    txn(1'b1, 1'b0, 32'h34F, '0, te, ta, oth);
    check("t2r_addr", en_addr, 32'h340);
    check("t2r_dc_rdata", dc_rdata, line_of(32'h340));
    check("t2r_ic_rdata_kept", ic_rdata, line_of(32'h100));
    check("t2r_idle", busy, 0);

    // Simultaneous requests right after reset
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    dc_req = 1; dc_we = 0; dc_addr = 32'h600; ic_req = 1; ic_addr = 32'h700;
    collect(2, 1'b0);
    check("t3_first_d", ack_who[0], 1);
    check("t3_then_i", ack_who[1], 0);
    check("t3_gap", ack_cyc[1] - ack_cyc[0], L0 + 3);
    check("t3_dc_rdata", dc_rdata, line_of(32'h600));
    check("t3_ic_rdata", ic_rdata, line_of(32'h700));
    dc_req = 1; dc_addr = 32'h610; ic_req = 1; ic_addr = 32'h710;
    collect(2, 1'b0);
    check("t3b_first_d", ack_who[0], 1);
    check("t3b_then_i", ack_who[1], 0);

    // D held continuously with an I request pending
    dc_req = 1; dc_we = 0; dc_addr = 32'h800;
    repeat (2) @(negedge clk);
    ic_req = 1; ic_addr = 32'h900;
    collect(3, 1'b1);
    check("t4_who0", ack_who[0], 1);
    check("t4_who1", ack_who[1], 0);
    check("t4_who2", ack_who[2], 1);
    check("t4_gap1", ack_cyc[1] - ack_cyc[0], L0 + 3);
    check("t4_gap2", ack_cyc[2] - ack_cyc[1], L0 + 3);
    check("t4_ic_rdata", ic_rdata, line_of(32'h900));

    // Reset during ACCESS
    ic_req = 1; ic_addr = 32'hA00;
    for (int k = 0; k < 10 && !mem_en; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_mem_en", mem_en, 0);
    check("t5_acks", {ic_ack, dc_ack}, 0);
    check("t5_ic_rdata", ic_rdata, 0);
    check("t5_dc_rdata", dc_rdata, 0);
    check("t5_mem_addr", mem_addr, 0);
    ic_req = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nack = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ic_ack || dc_ack) nack++;
    end
    check("t5_no_stale_ack", nack, 0);
    txn(1'b0, 1'b0, 32'h7F8, '0, te, ta, oth);
    check("t5_fresh_en", te, 1);
    check("t5_fresh_ack", ta, L0 + 2);
    check("t5_fresh_rdata", ic_rdata, line_of(32'h7F0));

    // Latency-1 build, address changed during ACCESS
    ic_req1 = 1; ic_addr1 = 32'h55C;
    t0 = cyc; te = -1; ta = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_en1 && te < 0) begin te = cyc - t0; en_addr = mem_addr1; ic_addr1 = 32'hFFF0; end
      if (ic_ack1) begin
        ta = cyc - t0;
        check("t6_addr_held", mem_addr1, 32'h550);
        ic_req1 = 0;
        break;
      end
    end
    check("t6_en_lat", te, 1);
    check("t6_addr", en_addr, 32'h550);
    check("t6_ack_lat", ta, 3);
    check("t6_rdata", ic_rdata1, line_of(32'h550));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
